lockstep_scheduler: RTL

Sequences the two-core relational verification harness. It issues a per-core clock-enable so that both cores retire instructions in lockstep pairs, and emits one pair-retire strobe per instruction pair to the contract checker. It also counts retired pairs and ends the run when both cores pass the program end address or a retire budget is reached. Lost lockstep (one core never retires) and global stalls are flagged as timeouts.

---
 rtl/lockstep_scheduler.sv | 116 +++++++++++
 1 files changed

// File: rtl/lockstep_scheduler.sv
// Lockstep sequencer for the two-core relational harness: gates each core's clock so
// retires pair up, strobes once per pair, and ends the run on budget, end address or timeout.
module lockstep_scheduler #(
    parameter int          RETIRE_W    = 16,
    parameter logic [15:0] MAX_RETIRE  = 16'd256,
    parameter logic [31:0] END_ADDR    = 32'h0000_0400,
    parameter int          MAX_SKEW    = 32,
    parameter int          MAX_STALL   = 256
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    input  logic                retire_1_i,
    input  logic                retire_2_i,
    input  logic [31:0]         instr_addr_1_i,
    input  logic [31:0]         instr_addr_2_i,
    output logic                run_1_o,
    output logic                run_2_o,
    output logic                retire_o,
    output logic [RETIRE_W-1:0] retire_cnt_o,
    output logic                busy_o,
    output logic                finished_o,
    output logic                timeout_o
);
    localparam int SKEW_W  = $clog2(MAX_SKEW + 1);
    localparam int STALL_W = $clog2(MAX_STALL + 1);
    localparam logic [SKEW_W-1:0]   SKEW_LAST  = SKEW_W'(MAX_SKEW - 1);
    localparam logic [STALL_W-1:0]  STALL_LAST = STALL_W'(MAX_STALL - 1);
    localparam logic [RETIRE_W-1:0] CNT_MAX    = RETIRE_W'(MAX_RETIRE);

    typedef enum logic [2:0] {
        IDLE, RUN, WAIT_2, WAIT_1, PAIR, DONE, TIMEOUT
    } state_e;

    state_e              state_q, state_d;
    logic [RETIRE_W-1:0] cnt_q, cnt_d;
    logic [SKEW_W-1:0]   skew_q, skew_d;
    logic [STALL_W-1:0]  stall_q, stall_d;
    logic                ret_1, ret_2;
    logic [RETIRE_W-1:0] cnt_inc;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            skew_q  <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            skew_q  <= skew_d;
            stall_q <= stall_d;
        end
    end

    assign run_1_o      = (state_q == RUN) || (state_q == WAIT_1);
    assign run_2_o      = (state_q == RUN) || (state_q == WAIT_2);
    assign retire_o     = (state_q == PAIR);
    assign retire_cnt_o = cnt_q;
    assign busy_o       = (state_q == RUN) || (state_q == WAIT_1) ||
                          (state_q == WAIT_2) || (state_q == PAIR);
    assign finished_o   = (state_q == DONE);
    assign timeout_o    = (state_q == TIMEOUT);

    // A halted core may hold retire high; only count it while its clock is enabled.
    assign ret_1   = retire_1_i && run_1_o;
    assign ret_2   = retire_2_i && run_2_o;
    assign cnt_inc = cnt_q + RETIRE_W'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        skew_d  = skew_q;
        stall_d = stall_q;
        case (state_q)
            IDLE, DONE, TIMEOUT: begin
                if (start_i) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    skew_d  = '0;
                    stall_d = '0;
                end
            end
            RUN: begin
                if (ret_1 || ret_2) begin
                    stall_d = '0;
                    skew_d  = '0;
                    if (ret_1 && ret_2) state_d = PAIR;
                    else if (ret_1)     state_d = WAIT_2;
                    else                state_d = WAIT_1;
                end else begin
                    stall_d = stall_q + STALL_W'(1);
                    if (stall_q == STALL_LAST) state_d = TIMEOUT;
                end
            end
            WAIT_1, WAIT_2: begin
                if ((state_q == WAIT_2) ? ret_2 : ret_1) begin
                    state_d = PAIR;
                    skew_d  = '0;
                end else begin
                    skew_d = skew_q + SKEW_W'(1);
                    if (skew_q == SKEW_LAST) state_d = TIMEOUT;
                end
            end
            PAIR: begin
                cnt_d = cnt_inc;
                if ((cnt_inc == CNT_MAX) ||
                    ((instr_addr_1_i >= END_ADDR) && (instr_addr_2_i >= END_ADDR)))
                    state_d = DONE;
                else
                    state_d = RUN;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule
